// File: rtl/sar_search.sv
// rtl/sar_search.sv - successive-approximation search driven by an external comparator
// Finds the largest unsigned v <= hidden target, one bit per cycle, MSB first.
module sar_search #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         trial_gt,
  output logic [N-1:0] trial,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEARCH = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic [IW-1:0] IDX_TOP = IW'(N - 1);

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [N-1:0]  result_q, result_d;
  logic [N-1:0]  bit_mask;

  assign bit_mask = {{(N-1){1'b0}}, 1'b1} << idx_q;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SEARCH;
          acc_d   = '0;
          idx_d   = IDX_TOP;
        end
      end
      ST_SEARCH: begin
        // Keep the trial bit only when the trial did not overshoot the target.
        if (trial_gt) begin
          acc_d = acc_q & ~bit_mask;
        end else begin
          acc_d = acc_q | bit_mask;
        end
        if (idx_q != '0) begin
          idx_d = idx_q - IW'(1);
        end else begin
          state_d  = ST_DONE;
          result_d = acc_d;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      idx_q    <= IDX_TOP;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      result_q <= result_d;
    end
  end

  // Outputs decode straight from state so reset clears them without a clock edge.
  assign busy   = (state_q == ST_SEARCH);
  assign done   = (state_q == ST_DONE);
  assign trial  = busy ? (acc_q | bit_mask) : '0;
  assign result = result_q;

endmodule

// File: tb/tb_sar_search.sv
// tb/tb_sar_search.sv - randomized self-checking bench for sar_search (N=8 and N=32)
module tb_sar_search;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8, start32;
  logic        noise;
  logic [7:0]  tgt8;
  logic [31:0] tgt32;

  logic [7:0]  trial8, result8;
  logic        busy8, done8, gt8;
  logic [31:0] trial32, result32;
  logic        busy32, done32, gt32;

  int checks = 0;
  int failures = 0;
  int dcnt8 = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  always @(negedge clk) noise <= 1'($urandom_range(0, 1));
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done8) dcnt8 <= dcnt8 + 1;
  end

  // Comparator is only meaningful in SEARCH; feed garbage elsewhere.
  assign gt8  = busy8  ? (trial8 > tgt8)   : noise;
  assign gt32 = busy32 ? (trial32 > tgt32) : noise;

  sar_search #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .trial_gt(gt8),
    .trial(trial8), .busy(busy8), .done(done8), .result(result8)
  );

  sar_search #(.N(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .trial_gt(gt32),
    .trial(trial32), .busy(busy32), .done(done32), .result(result32)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected trial at bit k: target's bits above k, a 1 at k, zeros below.
  function automatic logic [63:0] exp_trial(input logic [63:0] tgt, input int k);
    logic [63:0] hi;
    hi = (tgt >> (k + 1)) << (k + 1);
    return hi | (64'd1 << k);
  endfunction

  task automatic run8(input logic [7:0] t, input bit repulse);
    int d0;
    tgt8 = t;
    d0 = dcnt8;
    @(negedge clk);
    start8 = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start8 = 1'b0;
      if (c <= 8) begin
        check("s8_busy", busy8, 1);
        check("s8_trial", trial8, exp_trial(t, 8 - c) & 64'hFF);
        check("s8_done_low", done8, 0);
      end else if (c == 9) begin
        check("s8_done", done8, 1);
        check("s8_busy_done", busy8, 0);
        check("s8_trial_done", trial8, 0);
        check("s8_result", result8, t);
      end else begin
        check("s8_done_after", done8, 0);
        check("s8_busy_after", busy8, 0);
        check("s8_trial_after", trial8, 0);
        check("s8_result_hold", result8, t);
      end
      start8 = repulse && (c == 3 || c == 9);
    end
    start8 = 1'b0;
    if (repulse) begin
      @(negedge clk);
      check("repulse_idle", busy8, 0);
      check("repulse_one_done", dcnt8 - d0, 1);
    end
  endtask

  task automatic run32(input logic [31:0] t);
    tgt32 = t;
    @(negedge clk);
    start32 = 1'b1;
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      start32 = 1'b0;
      if (c <= 32) begin
        check("s32_busy", busy32, 1);
        check("s32_trial", trial32, exp_trial(t, 32 - c) & 64'hFFFF_FFFF);
        check("s32_done_low", done32, 0);
      end else begin
        check("s32_done", done32, 1);
        check("s32_result", result32, t);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, got, t1, t2;
    rst = 1'b1; start8 = 1'b0; start32 = 1'b0; tgt8 = '0; tgt32 = '0;
    #2;
    check("rst_trial8", trial8, 0);
    check("rst_busy8", busy8, 0);
    check("rst_done8", done8, 0);
    check("rst_result8", result8, 0);
    check("rst_trial32", trial32, 0);
    check("rst_result32", result32, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // start honoured at the first edge after reset release
    run8(8'd100, 1'b0);
    run8(8'd0, 1'b0);
    run8(8'd255, 1'b0);
    run8(8'd100, 1'b1);

    // async reset mid-search
    tgt8 = 8'd100;
    d0 = dcnt8;
    @(negedge clk);
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy", busy8, 1);
    #1 rst = 1'b1;
    #1;
    check("arst_trial", trial8, 0);
    check("arst_busy", busy8, 0);
    check("arst_done", done8, 0);
    check("arst_result", result8, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("arst_no_done", dcnt8 - d0, 0);
    check("arst_result_hold", result8, 0);
    run8(8'd37, 1'b0);

    // start held high: back-to-back searches
    tgt8 = 8'd200;
    got = 0; t1 = 0; t2 = 0;
    @(negedge clk);
    start8 = 1'b1;
    for (int i = 0; i < 40 && got < 2; i++) begin
      @(negedge clk);
      if (done8) begin
        got++;
        if (got == 1) begin
          t1 = cyc;
          check("hold_res1", result8, 200);
          tgt8 = 8'd55;
        end else begin
          t2 = cyc;
          check("hold_res2", result8, 55);
          start8 = 1'b0;
        end
      end
    end
    start8 = 1'b0;
    check("hold_dones", got, 2);
    check("hold_period", t2 - t1, 10);
    repeat (12) @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      run8(8'($urandom), 1'($urandom_range(0, 1)));
    end

    run32(32'hDEAD_BEEF);
    run32(32'h0);
    run32(32'hFFFF_FFFF);
    for (int i = 0; i < 6; i++) begin
      run32($urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sar_search.md
SAR_SEARCH -- requirements
Module: sar_search

Interface
REQ-001 Parameter: N, 32, width of trial value and result in bits.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  request a new search; sampled only in IDLE.
REQ-005 Port: trial_gt  input  1  external comparator verdict: 1 when the presented trial exceeds the hidden target (unsigned); combinational and valid in the same cycle as trial.
REQ-006 Port: trial  output  N  candidate value driven to the external comparator.
REQ-007 Port: busy  output  1  high while in SEARCH.
REQ-008 Port: done  output  1  single-cycle pulse marking result valid.
REQ-009 Port: result  output  N  final search value; holds until the next accepted start.

Function
REQ-010 The block SHALL implement a successive-approximation search that finds the largest unsigned v in [0, 2^N-1] with v <= target, using only trial_gt.
REQ-011 States SHALL be IDLE, SEARCH, DONE; encoding is free.
REQ-012 IDLE: trial = 0, busy = 0, done = 0; start = 1 at an edge -> SEARCH with acc = 0 and bit index = N-1.
REQ-013 SEARCH: trial SHALL equal acc with bit[index] forced to 1; busy = 1.
REQ-014 At each SEARCH edge, acc[index] SHALL be set to ~trial_gt and all other acc bits kept.
REQ-015 If index > 0, the index SHALL decrement by 1 and the state SHALL remain SEARCH.
REQ-016 If index = 0, the state SHALL go to DONE and result SHALL load the final acc, including the bit decided that cycle.
REQ-017 SEARCH SHALL last exactly N cycles; DONE SHALL follow on cycle N+1 after the start edge.
REQ-018 DONE SHALL last exactly one cycle with done = 1, busy = 0, trial = 0, then return to IDLE unconditionally.
REQ-019 start SHALL be ignored in SEARCH and DONE; a search is never restarted or queued.
REQ-020 start held high continuously SHALL launch a new search on the first IDLE cycle after each DONE; the resulting cadence is one search per N+2 cycles.
REQ-021 result SHALL change only on the SEARCH->DONE transition and under reset.
REQ-022 trial_gt SHALL be ignored outside SEARCH.
REQ-023 Index arithmetic SHALL use ceil(log2 N) bits and SHALL never wrap below 0.
REQ-024 The design SHALL operate for any N >= 2.

Reset
REQ-025 rst = 1 SHALL immediately, without waiting for a clock edge, force state IDLE, acc = 0, index = N-1, result = 0, done = 0, busy = 0, trial = 0.
REQ-026 Reset asserted mid-SEARCH SHALL abandon the search with no done pulse and no result update.
REQ-027 After rst deasserts, the first start SHALL be honoured at the first rising edge at which it is high.

Verification
REQ-028 N=8, target=100, start pulsed one cycle -> busy for 8 cycles; trial sequence 128,64,96,112,104,100,102,101; done pulse on cycle 9; result = 100.
REQ-029 N=8, target=0 -> result = 0. Target=255 -> result = 255, with trial_gt = 0 every SEARCH cycle.
REQ-030 N=8, target=100, start re-pulsed during cycles 3 and 9 -> both ignored; exactly one done; result = 100; trial = 0 on cycle 10.
REQ-031 N=8, rst asserted asynchronously mid-cycle during SEARCH cycle 4 -> outputs zero before the next edge; no done; result stays 0; a fresh search for target=37 then yields 37.
REQ-032 N=8, start held high, target changed from 200 to 55 after the first done -> results 200 then 55; done pulses exactly 10 cycles apart.
REQ-033 N=32, target=0xDEADBEEF, bench comparator modelled as unsigned trial > target -> result = 0xDEADBEEF on cycle 33.
